nibble_serial_add_ctrl: RTL

Sequencer that performs a wide add (4*NIBBLES bits) through the team's existing combinational 4-bit full adder (ports a, b, cin, o, cout), one nibble per clock.
- Upstream side: accepts wide operands and carry-in over a valid/ready handshake.
- Adder side: drives the adder's a/b/cin and consumes its o/cout, rippling the carry between cycles.
- Downstream side: presents the assembled sum and final carry over a valid/ready handshake.

---
 rtl/nibble_serial_add_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: runs a 4*NIBBLES-bit add through an external
// combinational 4-bit adder, one nibble per clock, LSB nibble first.
// Operands are taken over a valid/ready handshake. The result is returned
// over a valid/ready handshake and held stable until it is accepted.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
  output logic [3:0]             fa_a,
  output logic [3:0]             fa_b,
  output logic                   fa_cin,
  input  logic [3:0]             fa_o,
  input  logic                   fa_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout
);

  // The nibble index is at least 1 bit wide, so NIBBLES=1 still elaborates.
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [NIBBLES-1:0][3:0]   r_a;
  logic [NIBBLES-1:0][3:0]   r_b;
  logic [NIBBLES-1:0][3:0]   r_sum;
  logic                      r_carry;
  logic                      r_cout;
  logic [IW-1:0]             r_idx;
  logic                      w_last;

  assign w_last   = (r_idx == LAST);
  assign out_sum  = r_sum;
  assign out_cout = r_cout;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state, handshake flags and the adder drive. The adder inputs are
  // forced to zero outside RUN so that the adder sees no stray operands.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    fa_a      = 4'h0;
    fa_b      = 4'h0;
    fa_cin    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        fa_a   = r_a[r_idx];
        fa_b   = r_b[r_idx];
        fa_cin = r_carry;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then collect one sum nibble per
  // cycle and ripple the carry. out_cout only changes on the last nibble,
  // so it keeps the previous result until the new one is complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        S_RUN: begin
          r_sum[r_idx] <= fa_o;
          r_carry      <= fa_cout;
          if (w_last) r_cout <= fa_cout;
          else        r_idx  <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
